// File: rtl/uart_tx_io.sv
// uart_tx_io: CPU-side UART transmitter. A byte FIFO feeds a baud-timed 8N1 serialiser (LSB first).
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit (11-bit frames).
module uart_tx_io #(
    parameter int CLK_FREQ   = 23_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic                        clr_ovf,
    output logic                        full,
    output logic                        empty,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        tx,
    output logic [2:0]                  dbg_state
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    logic fifo_empty, fifo_full, baud_last, pop, accept;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LVL_FULL);
    assign baud_last  = (baud_q == BAUD_LAST);

    // wr_en is a fire-and-forget strobe with no ready: the byte is taken when the FIFO
    // has room or is popping this same cycle; otherwise it is dropped and overflow sets.
    assign accept = wr_en && (!fifo_full || pop);

    // Serialiser: pop happens only on entry to START (from IDLE or at the end of STOP).
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d    = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef UART_TX_PARITY_EN
    assign par_d = pop ? ^mem_q[rptr_q] : par_q;
`endif

    // The line level is registered from the next state so tx is glitch-free.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wptr_d  = accept ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
        ovf_d = ovf_q;
        if (wr_en && !accept) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    assign full      = fifo_full;
    assign empty     = fifo_empty;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign overflow  = ovf_q;
    assign level     = count_q;
    assign tx        = tx_q;
    assign dbg_state = state_q;

endmodule
